// File: rtl/legv8_pkg.sv
// LEGv8 decode constants: instruction-format codes, opcode prefixes and the zero register.
// Shared by the ID stage and its register file.
package legv8_pkg;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_D  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_CB = 3'd4;
  localparam logic [2:0] FMT_IW = 3'd5;

  // Prefixes are matched against the top bits of the 11-bit opcode instr[31:21].
  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;
  localparam logic [6:0] OP_D     = 7'b1111000;
  localparam logic [8:0] OP_MOVZ  = 9'b110100101;
  localparam logic [8:0] OP_MOVK  = 9'b111100101;

  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;

  localparam int XZR = 31;

  function automatic logic is_imm_alu(input logic [9:0] op_hi);
    return op_hi inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                         OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI};
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Purpose: NREG x XLEN register file, 2 read / 1 write, zero register, write-through bypass.
// Latency: reads combinational (same-cycle write data forwarded); writes land at posedge.
// Backpressure: none; writes always accepted, reset clears every entry.
module regfile_bypass #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31,
  localparam int RAW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RAW-1:0]  rs1_idx,
  input  logic [RAW-1:0]  rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [RAW-1:0]  wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  localparam logic [RAW-1:0] ZR = RAW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_live;

  assign wr_live = wr_en && (wr_idx != ZR);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_idx];
    if (rs1_idx == ZR)                       rs1_data = '0;
    else if (wr_live && wr_idx == rs1_idx)   rs1_data = wr_data;

    rs2_data = regs[rs2_idx];
    if (rs2_idx == ZR)                       rs2_data = '0;
    else if (wr_live && wr_idx == rs2_idx)   rs2_data = wr_data;
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Purpose: LEGv8 ID stage: register read, format/immediate decode, ID/EX register.
// Latency: 1 cycle from IF/ID to ID/EX; load-use hazard inserts a bubble.
// Backpressure: id_ready drops while EX stalls a valid entry or a load-use hazard is seen.
module decode_stage_pipelined
  import legv8_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = XZR,
  localparam int RAW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            ex_is_load,
  input  logic [RAW-1:0]  ex_rd,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_reg,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [10:0]     id_opcode,
  output logic [2:0]      id_fmt,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic [RAW-1:0]  id_rd,
  output logic [XLEN-1:0] id_pc
);

  localparam logic [RAW-1:0] ZR = RAW'(ZERO_REG);

  logic [10:0]     opcode;
  logic [RAW-1:0]  rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [2:0]      fmt;
  logic            hazard, advance;

  assign opcode  = if_instr[31:21];
  assign rs1_idx = RAW'(if_instr[9:5]);
  // STUR and CBZ/CBNZ carry their second source (Rt) in the rd field.
  assign rs2_idx = RAW'(if_instr[28] ? if_instr[4:0] : if_instr[20:16]);

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .wr_en    (wb_we),
    .wr_idx   (wb_reg),
    .wr_data  (wb_data)
  );

  always_comb begin
    fmt = FMT_R;
    imm = '0;
    if (opcode[10:5] == OP_B || opcode[10:5] == OP_BL) begin
      fmt = FMT_B;
      imm = {{(XLEN-26){if_instr[25]}}, if_instr[25:0]};
    end else if (opcode[10:3] inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
      fmt = FMT_CB;
      imm = {{(XLEN-19){if_instr[23]}}, if_instr[23:5]};
    end else if (opcode[9:3] == OP_D) begin
      fmt = FMT_D;
      imm = {{(XLEN-9){if_instr[20]}}, if_instr[20:12]};
    end else if (opcode[10:2] == OP_MOVZ || opcode[10:2] == OP_MOVK) begin
      fmt = FMT_IW;
      imm = XLEN'(if_instr[20:5]) << {if_instr[22:21], 4'b0000};
    end else if (is_imm_alu(opcode[10:1])) begin
      fmt = FMT_I;
      imm = XLEN'(if_instr[21:10]);
    end
  end

  assign hazard   = if_valid && ex_is_load && (ex_rd != ZR) &&
                    (rs1_idx == ex_rd || rs2_idx == ex_rd);
  assign advance  = !id_valid || ex_ready;
  assign id_ready = advance && !hazard && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_opcode   <= '0;
      id_fmt      <= FMT_R;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_rd       <= '0;
      id_pc       <= '0;
    end else if (flush) begin
      id_valid    <= 1'b0;
    end else if (advance) begin
      id_valid    <= if_valid && !hazard;
      id_opcode   <= opcode;
      id_fmt      <= fmt;
      id_rs1_data <= rs1_val;
      id_rs2_data <= rs2_val;
      id_imm      <= imm;
      id_rd       <= RAW'(if_instr[4:0]);
      id_pc       <= if_pc;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed LEGv8 cases plus randomized traffic,
// all outputs compared each cycle against an instruction-level model.
module tb_decode_stage_pipelined;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        reset, if_valid, ex_ready, flush, ex_is_load, wb_we;
  logic [31:0] if_instr;
  logic [63:0] if_pc, wb_data;
  logic [4:0]  ex_rd, wb_reg;
  logic        id_ready, id_valid;
  logic [10:0] id_opcode;
  logic [2:0]  id_fmt;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [4:0]  id_rd;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage_pipelined dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_fmt(id_fmt),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rd(id_rd), .id_pc(id_pc)
  );

  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [10:0] m_op;
  logic [2:0]  m_fmt;
  logic [63:0] m_rs1, m_rs2, m_imm, m_pc;
  logic [4:0]  m_rd;
  logic [63:0] rf [32];
  logic [9:0]  ilist [8] = '{10'h244, 10'h2C4, 10'h344, 10'h3C4,
                             10'h248, 10'h3C8, 10'h2C8, 10'h348};

  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    int op;
    op = int'(ins[31:21]);
    if (op / 32 == 5 || op / 32 == 37) return FMT_B;
    if (op / 8 == 'hB4 || op / 8 == 'hB5 || op / 8 == 'h54) return FMT_CB;
    if ((op / 8) % 128 == 'h78) return FMT_D;
    if (op / 4 == 'h1A5 || op / 4 == 'h1E5) return FMT_IW;
    for (int i = 0; i < 8; i++) if (op / 2 == int'(ilist[i])) return FMT_I;
    return FMT_R;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    longint v;
    v = 0;
    case (ref_fmt(ins))
      FMT_B:  begin v = longint'(ins[25:0]); if (ins[25]) v = v - (longint'(1) << 26); end
      FMT_CB: begin v = longint'(ins[23:5]); if (ins[23]) v = v - (longint'(1) << 19); end
      FMT_D:  begin v = longint'(ins[20:12]); if (ins[20]) v = v - (longint'(1) << 9); end
      FMT_IW: v = longint'(ins[20:5]) * (longint'(1) << (16 * int'(ins[22:21])));
      FMT_I:  v = longint'(ins[21:10]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] ins);
    return ins[28] ? ins[4:0] : ins[20:16];
  endfunction

  function automatic logic [63:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (wb_we && wb_reg == idx) return wb_data;
    return rf[idx];
  endfunction

  function automatic logic ref_hazard();
    return if_valid && ex_is_load && ex_rd != 5'd31 &&
           (if_instr[9:5] == ex_rd || rs2_of(if_instr) == ex_rd);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_valid = 1'b0; m_op = '0; m_fmt = '0; m_rs1 = '0; m_rs2 = '0;
      m_imm = '0; m_rd = '0; m_pc = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
    end else begin
      if (flush) m_valid = 1'b0;
      else if (!m_valid || ex_ready) begin
        m_valid = if_valid && !ref_hazard();
        m_op  = if_instr[31:21];
        m_fmt = ref_fmt(if_instr);
        m_rs1 = ref_read(if_instr[9:5]);
        m_rs2 = ref_read(rs2_of(if_instr));
        m_imm = ref_imm(if_instr);
        m_rd  = if_instr[4:0];
        m_pc  = if_pc;
      end
      if (wb_we && wb_reg != 5'd31) rf[wb_reg] = wb_data;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("valid",  64'(id_valid),  64'(m_valid));
      chk("ready",  64'(id_ready),
          64'((!m_valid || ex_ready) && !ref_hazard() && !reset));
      chk("opcode", 64'(id_opcode), 64'(m_op));
      chk("fmt",    64'(id_fmt),    64'(m_fmt));
      chk("rs1",    id_rs1_data,    m_rs1);
      chk("rs2",    id_rs2_data,    m_rs2);
      chk("imm",    id_imm,         m_imm);
      chk("rd",     64'(id_rd),     64'(m_rd));
      chk("pc",     id_pc,          m_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b1; flush = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0; wb_we = 1'b0; wb_reg = '0; wb_data = '0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [63:0] d);
    wb_we = 1'b1; wb_reg = r; wb_data = d;
    cyc();
    wb_we = 1'b0;
  endtask

  function automatic logic [4:0] ridx();
    if ($urandom_range(0, 8) == 8) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:21] = 11'h458;
      1: r[31:26] = ($urandom_range(0, 1) == 1) ? 6'b100101 : 6'b000101;
      2: r[31:24] = ($urandom_range(0, 2) == 0) ? 8'hB4 : (($urandom_range(0, 1) == 1) ? 8'hB5 : 8'h54);
      3: r[30:24] = 7'b1111000;
      4: r[31:23] = ($urandom_range(0, 1) == 1) ? 9'h1A5 : 9'h1E5;
      5: r[31:22] = ilist[$urandom_range(0, 7)];
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) begin
      r[9:5] = ridx(); r[4:0] = ridx();
      if (!r[28]) r[20:16] = ridx();
    end
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    cyc(); cyc();
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_ready", 64'(id_ready), 64'd0);
    chk("rst_pc",    id_pc,         64'd0);
    reset = 1'b0;

    // ADD X3,X1,X2 with X1=5, X2=7
    wr(5'd1, 64'd5); wr(5'd2, 64'd7);
    if_valid = 1'b1; if_instr = 32'h8B020023; if_pc = 64'h100;
    cyc();
    chk("t1_valid", 64'(id_valid), 64'd1);
    chk("t1_rs1",   id_rs1_data,   64'd5);
    chk("t1_rs2",   id_rs2_data,   64'd7);
    chk("t1_rd",    64'(id_rd),    64'd3);
    chk("t1_fmt",   64'(id_fmt),   64'(FMT_R));
    chk("t1_imm",   id_imm,        64'd0);
    chk("t1_pc",    id_pc,         64'h100);

    // LDUR X5,[X1,#-8], then CBZ X7,#-4 reading Rt
    if_instr = 32'hF85F8025; if_pc = 64'h104;
    wb_we = 1'b1; wb_reg = 5'd7; wb_data = 64'h77;
    cyc();
    wb_we = 1'b0;
    chk("t2_ldur_fmt", 64'(id_fmt), 64'(FMT_D));
    chk("t2_ldur_imm", id_imm,      64'hFFFF_FFFF_FFFF_FFF8);
    chk("t2_ldur_rs1", id_rs1_data, 64'd5);
    if_instr = 32'hB4FFFF87; if_pc = 64'h108;
    cyc();
    chk("t2_cbz_fmt", 64'(id_fmt), 64'(FMT_CB));
    chk("t2_cbz_imm", id_imm,      64'hFFFF_FFFF_FFFF_FFFC);
    chk("t2_cbz_rs2", id_rs2_data, 64'h77);

    // same-cycle write-through, and XZR ignores writes
    if_instr = 32'h8B020023;
    wb_we = 1'b1; wb_reg = 5'd1; wb_data = 64'h1234;
    cyc();
    chk("t3_bypass", id_rs1_data, 64'h1234);
    if_instr = 32'h8B0203E3;
    wb_reg = 5'd31; wb_data = 64'hFF;
    cyc();
    wb_we = 1'b0;
    chk("t3_xzr_same", id_rs1_data, 64'd0);
    cyc();
    chk("t3_xzr_after", id_rs1_data, 64'd0);

    // load-use: ADD X6,X5,X2 behind a load to X5
    ex_is_load = 1'b1; ex_rd = 5'd5; if_instr = 32'h8B0200A6; if_pc = 64'h200;
    #1 chk("t4_ready_lo", 64'(id_ready), 64'd0);
    cyc();
    chk("t4_bubble", 64'(id_valid), 64'd0);
    ex_is_load = 1'b0;
    #1 chk("t4_ready_hi", 64'(id_ready), 64'd1);
    cyc();
    chk("t4_issue_v",  64'(id_valid), 64'd1);
    chk("t4_issue_rd", 64'(id_rd),    64'd6);
    chk("t4_issue_pc", id_pc,         64'h200);

    // EX stall holds the register, then flush kills it
    ex_ready = 1'b0; if_instr = 32'h8B020023; if_pc = 64'h300;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_ready", 64'(id_ready), 64'd0);
      cyc();
      chk("t5_hold_v",  64'(id_valid), 64'd1);
      chk("t5_hold_rd", 64'(id_rd),    64'd6);
      chk("t5_hold_pc", id_pc,         64'h200);
    end
    flush = 1'b1;
    cyc();
    chk("t5_flush", 64'(id_valid), 64'd0);
    flush = 1'b0; ex_ready = 1'b1;
    cyc();

    // reset mid-stream
    reset = 1'b1;
    cyc();
    chk("t6_valid", 64'(id_valid), 64'd0);
    chk("t6_pc",    id_pc,         64'd0);
    chk("t6_rs1",   id_rs1_data,   64'd0);
    reset = 1'b0; if_instr = 32'h8B020023;
    #1 chk("t6_ready", 64'(id_ready), 64'd1);
    cyc();
    chk("t6_x1_zero", id_rs1_data, 64'd0);
    chk("t6_valid2",  64'(id_valid), 64'd1);

    // pin the model's own immediate and format arithmetic
    chk("m_cbz_imm", ref_imm(32'hB4FFFF87), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("m_movk_imm", ref_imm(32'hF2E02460), 64'h0123_0000_0000_0000);
    chk("m_addi_fmt", 64'(ref_fmt(32'h91000C20)), 64'(FMT_I));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      if_valid   = ($urandom_range(0, 3) != 0);
      if_instr   = rand_instr();
      if_pc      = {$urandom, $urandom};
      ex_ready   = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 15) == 0);
      ex_is_load = ($urandom_range(0, 9) < 3);
      ex_rd      = ridx();
      wb_we      = ($urandom_range(0, 1) == 1);
      wb_reg     = ridx();
      wb_data    = {$urandom, $urandom};
      cyc();
    end
    idle(); reset = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
